// File: rtl/hwpe_stream_addressgen_v4.sv
// N-dimensional strided address generator: one address per fire, first beat visible the cycle after start.
// Backpressure: while valid && !ready, the address, last flags and all loop state hold.
module hwpe_stream_addressgen_v4 #(
  parameter int NB_DIMS    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT        = 16,
  parameter int TRANS_CNT  = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           enable_i,
  input  logic                           clear_i,
  input  logic                           start_i,
  input  logic [ADDR_WIDTH-1:0]          base_addr_i,
  input  logic [TRANS_CNT-1:0]           tot_len_i,
  input  logic [(NB_DIMS-1)*CNT-1:0]     len_i,
  input  logic [NB_DIMS*ADDR_WIDTH-1:0]  stride_i,
  output logic                           addr_valid_o,
  input  logic                           addr_ready_i,
  output logic [ADDR_WIDTH-1:0]          addr_data_o,
  output logic [ADDR_WIDTH/8-1:0]        addr_strb_o,
  output logic [NB_DIMS-2:0]             last_o,
  output logic                           busy_o,
  output logic                           done_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [TRANS_CNT-1:0]  tot_q, beat_q;
  logic [CNT-1:0]        len_q    [NB_DIMS-1];
  logic [ADDR_WIDTH-1:0] stride_q [NB_DIMS];
  logic [CNT-1:0]        cnt_q    [NB_DIMS];
  logic [ADDR_WIDTH-1:0] pa_q     [NB_DIMS];

  logic [NB_DIMS-2:0]    is_final;
  logic                  all_final;
  int                    adv_dim;
  logic [ADDR_WIDTH-1:0] addr_sum;
  logic                  fire, last_beat;

  assign fire      = (state_q == RUN) && addr_ready_i && enable_i;
  assign last_beat = (beat_q == tot_q - TRANS_CNT'(1));

  // A zero length behaves like a length of one.
  always_comb begin
    is_final  = '0;
    all_final = 1'b1;
    last_o    = '0;
    for (int d = 0; d < NB_DIMS-1; d++) begin
      is_final[d] = (len_q[d] == '0) ? (cnt_q[d] == '0)
                                     : (cnt_q[d] == len_q[d] - CNT'(1));
      all_final   = all_final & is_final[d];
      last_o[d]   = all_final & addr_valid_o;
    end
  end

  // Lowest non-final dimension advances; the top dimension catches the full carry.
  always_comb begin
    adv_dim = NB_DIMS-1;
    for (int d = NB_DIMS-2; d >= 0; d--) begin
      if (!is_final[d]) adv_dim = d;
    end
  end

  always_comb begin
    addr_sum = base_q;
    for (int d = 0; d < NB_DIMS; d++) addr_sum = addr_sum + pa_q[d];
  end

  assign addr_data_o  = addr_sum;
  assign addr_strb_o  = '1;
  assign addr_valid_o = (state_q == RUN);
  assign busy_o       = (state_q == RUN);
  assign done_o       = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = (tot_len_i == '0) ? DONE : RUN;
      RUN:     if (fire && last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        state_q <= IDLE;
    else if (clear_i)   state_q <= IDLE;
    else if (enable_i)  state_q <= state_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_q <= '0;
      tot_q  <= '0;
      beat_q <= '0;
      for (int d = 0; d < NB_DIMS; d++) begin
        cnt_q[d]    <= '0;
        pa_q[d]     <= '0;
        stride_q[d] <= '0;
      end
      for (int d = 0; d < NB_DIMS-1; d++) len_q[d] <= '0;
    end else if (clear_i) begin
      base_q <= '0;
      tot_q  <= '0;
      beat_q <= '0;
      for (int d = 0; d < NB_DIMS; d++) begin
        cnt_q[d]    <= '0;
        pa_q[d]     <= '0;
        stride_q[d] <= '0;
      end
      for (int d = 0; d < NB_DIMS-1; d++) len_q[d] <= '0;
    end else if (enable_i) begin
      if (state_q == IDLE && start_i) begin
        base_q <= base_addr_i;
        tot_q  <= tot_len_i;
        beat_q <= '0;
        for (int d = 0; d < NB_DIMS; d++) begin
          cnt_q[d]    <= '0;
          pa_q[d]     <= '0;
          stride_q[d] <= stride_i[d*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int d = 0; d < NB_DIMS-1; d++) len_q[d] <= len_i[d*CNT +: CNT];
      end else if (fire) begin
        beat_q <= beat_q + TRANS_CNT'(1);
        for (int d = 0; d < NB_DIMS; d++) begin
          if (d < adv_dim) begin
            cnt_q[d] <= '0;
            pa_q[d]  <= '0;
          end else if (d == adv_dim) begin
            cnt_q[d] <= cnt_q[d] + CNT'(1);
            pa_q[d]  <= pa_q[d] + stride_q[d];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_hwpe_stream_addressgen_v4.sv
// Randomised bench for the address generator: a mixed-radix loop model predicts every beat.
module tb_hwpe_stream_addressgen_v4;
  localparam int ND = 3;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int TW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, enable, clear, start, ready;
  logic [AW-1:0]     base_addr;
  logic [TW-1:0]     tot_len;
  logic [(ND-1)*CW-1:0] len;
  logic [ND*AW-1:0]  stride;
  logic              valid, busy, done;
  logic [AW-1:0]     data;
  logic [AW/8-1:0]   strb;
  logic [ND-2:0]     last;

  hwpe_stream_addressgen_v4 #(.NB_DIMS(ND), .ADDR_WIDTH(AW), .CNT(CW), .TRANS_CNT(TW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .clear_i(clear), .start_i(start),
    .base_addr_i(base_addr), .tot_len_i(tot_len), .len_i(len), .stride_i(stride),
    .addr_valid_o(valid), .addr_ready_i(ready), .addr_data_o(data), .addr_strb_o(strb),
    .last_o(last), .busy_o(busy), .done_o(done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] cfg_base;
  int          cfg_l0, cfg_l1;
  logic [31:0] cfg_s [3];

  function automatic logic [31:0] exp_addr(input int i);
    int i0, i1, i2;
    i0 = i % cfg_l0;
    i1 = (i / cfg_l0) % cfg_l1;
    i2 = i / (cfg_l0 * cfg_l1);
    return cfg_base + 32'(i0) * cfg_s[0] + 32'(i1) * cfg_s[1] + 32'(i2) * cfg_s[2];
  endfunction

  function automatic logic [1:0] exp_last(input int i);
    logic b0, b1;
    b0 = ((i % cfg_l0) == cfg_l0 - 1);
    b1 = b0 && (((i / cfg_l0) % cfg_l1) == cfg_l1 - 1);
    return {b1, b0};
  endfunction

  task automatic do_start(input logic [31:0] b, input int tot, input int l0, input int l1,
                          input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2);
    base_addr = b;
    tot_len   = TW'(tot);
    len       = {16'(l1), 16'(l0)};
    stride    = {s2, s1, s0};
    cfg_base  = b;
    cfg_l0    = (l0 == 0) ? 1 : l0;
    cfg_l1    = (l1 == 0) ? 1 : l1;
    cfg_s[0]  = s0;
    cfg_s[1]  = s1;
    cfg_s[2]  = s2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_stream(input int first, input int upto, input int pct, output int cyc);
    int idx;
    bit held;
    logic [31:0] hd;
    logic [1:0]  hl;
    idx = first; held = 0; cyc = 0; hd = '0; hl = '0;
    while (idx < upto && cyc < 4000) begin
      ready = ($urandom_range(99) < pct);
      if (held) begin
        n_tests++;
        if (valid !== 1'b1 || data !== hd || last !== hl) begin
          n_fail++;
          $display("FAIL stall_hold beat %0d: valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                   idx, valid, data, last, hd, hl);
        end
      end
      if (valid === 1'b1) begin
        if (ready) begin
          n_tests++;
          if (data !== exp_addr(idx) || last !== exp_last(idx)) begin
            n_fail++;
            $display("FAIL beat %0d: data=%h last=%b, want data=%h last=%b",
                     idx, data, last, exp_addr(idx), exp_last(idx));
          end
          idx++;
          held = 0;
        end else begin
          held = 1; hd = data; hl = last;
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (idx < upto) begin
      n_tests++; n_fail++;
      $display("FAIL stream_timeout: reached beat %0d, want %0d", idx, upto);
    end
  endtask

  task automatic check_done();
    n_tests++;
    if (done !== 1'b1 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: done=%b valid=%b busy=%b, want 1 0 0", done, valid, busy);
    end
    ready = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL done_width: done=%b valid=%b busy=%b, want 0 0 0", done, valid, busy);
    end
  endtask

  task automatic check_idle_outputs(input string name);
    n_tests++;
    if (valid !== 1'b0 || data !== '0 || last !== '0 || busy !== 1'b0 || done !== 1'b0 || strb !== '1) begin
      n_fail++;
      $display("FAIL %s: valid=%b data=%h last=%b busy=%b done=%b strb=%h, want 0 0 0 0 0 f",
               name, valid, data, last, busy, done, strb);
    end
  endtask

  task automatic start_walk();
    do_start(32'h1000, 8, 3, 2, 32'h4, 32'h100, 32'h1000);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; clear = 1'b0; start = 1'b0; ready = 1'b0;
    base_addr = '0; tot_len = '0; len = '0; stride = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset_state");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("after_reset_release");
  endtask

  task automatic test_walk_3d();
    int cyc;
    start_walk();
    n_tests++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL start_latency: valid=%b busy=%b, want 1 1", valid, busy);
    end
    run_stream(0, 8, 100, cyc);
    n_tests++;
    if (cyc !== 8) begin
      n_fail++;
      $display("FAIL throughput: %0d cycles for 8 beats, want 8", cyc);
    end
    check_done();
  endtask

  task automatic test_backpressure();
    int cyc;
    start_walk();
    run_stream(0, 8, 50, cyc);
    check_done();
  endtask

  task automatic test_neg_stride();
    int cyc;
    do_start(32'h8, 4, 5, 1, 32'hFFFF_FFFC, 32'h0, 32'h0);
    run_stream(0, 4, 60, cyc);
    check_done();
  endtask

  task automatic test_zero_len();
    do_start(32'h40, 0, 2, 2, 32'h4, 32'h8, 32'h10);
    n_tests++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_len: valid=%b busy=%b done=%b, want 0 0 1", valid, busy, done);
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_len_done_width: done=%b valid=%b, want 0 0", done, valid);
    end
  endtask

  task automatic test_enable();
    int cyc;
    start_walk();
    run_stream(0, 3, 100, cyc);
    enable = 1'b0;
    ready  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_tests++;
      if (valid !== 1'b1 || data !== exp_addr(3) || done !== 1'b0) begin
        n_fail++;
        $display("FAIL enable_freeze cycle %0d: valid=%b data=%h done=%b, want 1 %h 0",
                 k, valid, data, done, exp_addr(3));
      end
    end
    enable = 1'b1;
    run_stream(3, 8, 100, cyc);
    check_done();
  endtask

  task automatic test_clear();
    int cyc;
    start_walk();
    run_stream(0, 4, 100, cyc);
    ready = 1'b0;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check_idle_outputs("clear_outputs");
    @(posedge clk); #1;
    check_idle_outputs("clear_no_done");
    base_addr = 32'h1000; tot_len = 8;
    start = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear = 1'b0;
    check_idle_outputs("start_with_clear");
    start_walk();
    run_stream(0, 8, 100, cyc);
    check_done();
  endtask

  task automatic test_reset_midrun();
    int cyc;
    start_walk();
    run_stream(0, 3, 100, cyc);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("reset_midrun");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("reset_midrun_release");
  endtask

  task automatic test_config_isolation();
    int cyc;
    start_walk();
    run_stream(0, 2, 100, cyc);
    base_addr = $urandom;
    tot_len   = TW'($urandom_range(50, 1));
    len       = {16'($urandom_range(7)), 16'($urandom_range(7))};
    stride    = {$urandom, $urandom, $urandom};
    ready     = 1'b0;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++;
    if (valid !== 1'b1 || data !== exp_addr(2)) begin
      n_fail++;
      $display("FAIL restart_ignored: valid=%b data=%h, want 1 %h", valid, data, exp_addr(2));
    end
    run_stream(2, 8, 50, cyc);
    check_done();
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int it = 0; it < 6; it++) begin
      do_start($urandom, $urandom_range(30, 1), $urandom_range(4), $urandom_range(3),
               $urandom, $urandom, $urandom);
      run_stream(0, int'(tot_len), $urandom_range(100, 30), cyc);
      check_done();
    end
  endtask

  initial begin
    test_reset();
    test_walk_3d();
    test_backpressure();
    test_neg_stride();
    test_zero_len();
    test_enable();
    test_clear();
    test_reset_midrun();
    test_config_isolation();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_addressgen_v4.md
# hwpe_stream_addressgen_v4

Parametrised N-dimensional address generator for HWPE streamers. It walks a nested loop space of `NB_DIMS` dimensions with a signed byte stride per dimension and emits one byte address per accepted beat on an HWPE-Stream source. Compared with the fixed four-dimension generator, it adds a true valid/ready handshake (state advances only on a fire), a start/busy/done control FSM, configuration latched at start, and per-dimension `last` markers that travel with each address beat. It sits between the streamer controller and the TCDM load/store stream units.

## Interface
- `NB_DIMS`, default 4: number of loop dimensions; minimum 2. Dimension 0 is the innermost.
- `ADDR_WIDTH`, default 32: address and stride width.
- `CNT`, default 16: width of each per-dimension counter.
- `TRANS_CNT`, default 32: width of the total-transaction counter.

Ports:
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `enable_i`  in  1  when 0, all state is frozen.
- `clear_i`  in  1  synchronous clear back to IDLE.
- `start_i`  in  1  single-cycle pulse that latches the configuration and begins generation; honoured in IDLE only.
- `base_addr_i`  in  ADDR_WIDTH  byte base address.
- `tot_len_i`  in  TRANS_CNT  total number of beats.
- `len_i`  in  (NB_DIMS-1)*CNT  iteration counts for dimensions 0..NB_DIMS-2, packed with dimension 0 in the LSBs. The top dimension has no length.
- `stride_i`  in  NB_DIMS*ADDR_WIDTH  signed byte stride per dimension, packed with dimension 0 in the LSBs.
- `addr_o`  hwpe_stream_intf_stream.source  ADDR_WIDTH  output address stream; `strb` is tied to all ones.
- `last_o`  out  NB_DIMS-1  bit k is 1 when the current beat closes dimension k. Qualified by `addr_o.valid`.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse after the final beat fires.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE → RUN** on `start_i` with `tot_len_i` > 0:
  - latch base, lengths, strides and total;
  - clear all counters and partial addresses;
  - set `valid` = 1 with `data` = base.
- **IDLE → DONE** on `start_i` with `tot_len_i` == 0. No beat is emitted.
- **Fire** is `valid && ready`. On a fire in RUN:
  - Find the lowest dimension k whose counter is not final. A counter is final when it equals `len`-1; a `len` of 0 is treated as 1.
  - Increment counter k and add `stride[k]` to partial address k.
  - Reset counters and partial addresses of dimensions 0..k-1 to 0.
  - If every lower dimension is final, the top dimension increments without bound.
  - The beat counter increments.
- **RUN → DONE** when the fired beat is beat number `tot_len`. `valid` drops in the same edge.
- **DONE → IDLE** unconditionally on the next cycle. `done_o` is high only during DONE.
- **Output address:** `data` = base + sum of all partial addresses, computed modulo 2^ADDR_WIDTH. Two's-complement wrap-around is allowed; negative strides are legal.
- **Counter widths:** dimension counters are CNT bits; the top-dimension counter wraps silently.
- **last_o[k]:** combinational from the current counters. It is 1 iff counters 0..k are all final, so it marks the beat that completes dimension k.
- **Stall:** while `valid` && !`ready`, `data`, `last_o` and all state hold stable. `valid` never deasserts without a fire, except on `clear_i` or reset.
- **Mid-run inputs:** changes to the configuration inputs during RUN have no effect. `start_i` outside IDLE is ignored.

## Timing
- **Reset values:** FSM in IDLE, `addr_o.valid` = 0, `addr_o.data` = 0, `last_o` = 0, `busy_o` = 0, `done_o` = 0, all counters 0.
- **Start latency:** `start_i` sampled at edge t gives first `valid` and `busy_o` visible after edge t.
- **Throughput:** 1 beat per cycle with `ready` held high.
- **Done latency:** `done_o` asserts the cycle after the final fire and lasts exactly 1 cycle.
- **Priority:** `rst_ni` > `clear_i` > !`enable_i` > normal operation.
  - `clear_i` returns the FSM to IDLE with outputs at their reset values and does not pulse `done_o`.
  - With `enable_i` = 0, state is frozen and `valid` holds its current value. A `ready` during that time does not count as a fire.
- **Same-cycle start and clear:** `clear_i` wins and the start is lost.
- **Reset mid-run:** the FSM returns to IDLE immediately and asynchronously, with no `done_o`.

## Test plan
- **3-D walk:** `NB_DIMS`=3, base 0x1000, len={3,2}, stride={4,0x100,0x1000}, tot 8, `ready`=1 → addresses 1000, 1004, 1008, 1100, 1104, 1108, 2000, 2004 on consecutive cycles.
  - `last_o`[0] high on beats 3 and 6; `last_o`[1] high on beat 6.
  - `done_o` high for 1 cycle, 1 cycle after beat 8.
- **Back-pressure:** same configuration with random `ready` at 50% → identical address sequence; `data` stable on every stalled cycle; no beat lost or duplicated.
- **Negative stride and wrap:** base 0x0000_0008, stride0 = -4, len0 = 5, tot 4 → 0x8, 0x4, 0x0, 0xFFFF_FFFC.
- **Zero length:** `start_i` with tot 0 → no `valid`; `done_o` high 1 cycle after start.
- **Control:**
  - `enable_i` low for 3 cycles mid-run → sequence resumes unchanged.
  - `clear_i` at beat 4 → `valid` 0, `busy_o` 0, no `done_o`; a new start restarts at base.
  - Reset asserted mid-run → all outputs at reset values.
- **Config isolation:** change `len_i` and `stride_i` during RUN → output sequence unaffected; `start_i` during RUN ignored.
